// File: rtl/mux4_scan_if.sv
// Valid/ready bundle between the mux sequencer and its word source / bit sink.
// master = source+sink side, slave = sequencer.
interface mux4_scan_if;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic [3:0] chan_mask;
  logic       out_valid;
  logic       out_ready;
  logic       out_bit;
  logic [1:0] out_chan;
  logic       out_last;

  modport master (
    output in_valid, in_data, chan_mask, out_ready,
    input  in_ready, out_valid, out_bit, out_chan, out_last
  );

  modport slave (
    input  in_valid, in_data, chan_mask, out_ready,
    output in_ready, out_valid, out_bit, out_chan, out_last
  );
endinterface

// File: rtl/mux4_scan_ctrl.sv
// Sequencer for a 4:1 mux: latches a word, walks the enabled
// channels in ascending order and streams the mux output serially.
module mux4_scan_ctrl #(
  parameter int GAP   = 0,
  parameter int GAP_W = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  mux4_scan_if.slave  bus,
  output logic        i0_o,
  output logic        i1_o,
  output logic        i2_o,
  output logic        i3_o,
  output logic        sel1_o,
  output logic        sel0_o,
  input  logic        mux_y_i,
  output logic        drop_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_GAP
  } state_e;

  state_e           state_q;
  logic [3:0]       data_q;
  logic [3:0]       mask_q;
  logic [1:0]       sel_q;
  logic             valid_q;
  logic             last_q;
  logic             drop_q;
  logic [GAP_W-1:0] gap_q;

  logic [1:0]       first_sel_d;
  logic             first_last_d;
  logic [1:0]       step_sel_d;
  logic             step_last_d;

  function automatic logic [1:0] low_idx(input logic [3:0] m);
    logic [1:0] r;
    r = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (m[k]) r = 2'(k);
    end
    return r;
  endfunction

  // Bits strictly above channel c; empty means c is the final beat.
  function automatic logic [3:0] above(input logic [1:0] c);
    return 4'b1110 << c;
  endfunction

  always_comb begin
    first_sel_d  = low_idx(bus.chan_mask);
    first_last_d = ~|(bus.chan_mask & above(first_sel_d));
    step_sel_d   = low_idx(mask_q & above(sel_q));
    step_last_d  = ~|(mask_q & above(step_sel_d));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      data_q  <= 4'd0;
      mask_q  <= 4'd0;
      sel_q   <= 2'd0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      drop_q  <= 1'b0;
      gap_q   <= '0;
    end else begin
      drop_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (bus.in_valid) begin
            data_q <= bus.in_data;
            mask_q <= bus.chan_mask;
            if (bus.chan_mask == 4'd0) begin
              drop_q <= 1'b1;
            end else begin
              sel_q   <= first_sel_d;
              last_q  <= first_last_d;
              valid_q <= 1'b1;
              state_q <= S_SCAN;
            end
          end
        end
        S_SCAN: begin
          if (bus.out_ready) begin
            if (last_q) begin
              valid_q <= 1'b0;
              last_q  <= 1'b0;
              if (GAP == 0) begin
                state_q <= S_IDLE;
              end else begin
                state_q <= S_GAP;
                gap_q   <= GAP_W'(GAP);
              end
            end else begin
              sel_q  <= step_sel_d;
              last_q <= step_last_d;
            end
          end
        end
        S_GAP: begin
          gap_q <= gap_q - GAP_W'(1);
          if (gap_q == GAP_W'(1)) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = rst_n & (state_q == S_IDLE);
  assign bus.out_valid = valid_q;
  assign bus.out_bit   = mux_y_i & valid_q;
  assign bus.out_chan  = sel_q;
  assign bus.out_last  = last_q;

  assign {i3_o, i2_o, i1_o, i0_o} = data_q;
  assign {sel1_o, sel0_o}         = sel_q;
  assign drop_o                   = drop_q;

endmodule

// File: tb/tb_mux4_scan_ctrl.sv
// Bench for mux4_scan_ctrl: GAP=0 and GAP=3 instances share stimulus
// and are checked every cycle against a beat-list model.
module tb_mux4_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [3:0] in_data = 4'd0;
  logic [3:0] chan_mask = 4'd0;
  logic       out_ready = 1'b0;

  int tests = 0;
  int fails = 0;
  bit started = 1'b0;

  always #5 clk = ~clk;

  mux4_scan_if if0 ();
  mux4_scan_if if3 ();

  wire [3:0] dv0, dv3;
  wire       s1_0, s0_0, s1_3, s0_3;
  wire       drop0, drop3;
  wire       my0, my3;

  assign if0.in_valid  = in_valid;
  assign if0.in_data   = in_data;
  assign if0.chan_mask = chan_mask;
  assign if0.out_ready = out_ready;
  assign if3.in_valid  = in_valid;
  assign if3.in_data   = in_data;
  assign if3.chan_mask = chan_mask;
  assign if3.out_ready = out_ready;

  // The 4:1 mux itself, built from the block's registered drives.
  assign my0 = dv0[{s1_0, s0_0}];
  assign my3 = dv3[{s1_3, s0_3}];

  mux4_scan_ctrl #(.GAP(0), .GAP_W(4)) u0 (
    .clk(clk), .rst_n(rst_n), .bus(if0.slave),
    .i0_o(dv0[0]), .i1_o(dv0[1]), .i2_o(dv0[2]), .i3_o(dv0[3]),
    .sel1_o(s1_0), .sel0_o(s0_0), .mux_y_i(my0), .drop_o(drop0)
  );

  mux4_scan_ctrl #(.GAP(3), .GAP_W(4)) u3 (
    .clk(clk), .rst_n(rst_n), .bus(if3.slave),
    .i0_o(dv3[0]), .i1_o(dv3[1]), .i2_o(dv3[2]), .i3_o(dv3[3]),
    .sel1_o(s1_3), .sel0_o(s0_3), .mux_y_i(my3), .drop_o(drop3)
  );

  logic       rdy_w  [2];
  logic       vld_w  [2];
  logic       bit_w  [2];
  logic       last_w [2];
  logic       drop_w [2];
  logic [1:0] chan_w [2];
  logic [1:0] sel_w  [2];
  logic [3:0] dat_w  [2];

  assign rdy_w[0]  = if0.in_ready;
  assign vld_w[0]  = if0.out_valid;
  assign bit_w[0]  = if0.out_bit;
  assign last_w[0] = if0.out_last;
  assign chan_w[0] = if0.out_chan;
  assign drop_w[0] = drop0;
  assign sel_w[0]  = {s1_0, s0_0};
  assign dat_w[0]  = dv0;
  assign rdy_w[1]  = if3.in_ready;
  assign vld_w[1]  = if3.out_valid;
  assign bit_w[1]  = if3.out_bit;
  assign last_w[1] = if3.out_last;
  assign chan_w[1] = if3.out_chan;
  assign drop_w[1] = drop3;
  assign sel_w[1]  = {s1_3, s0_3};
  assign dat_w[1]  = dv3;

  task automatic chk(input string nm, input logic [7:0] act,
                     input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h, want %0h", nm, $time, act, exp);
    end
  endtask

  // Model: at accept the frame becomes an ordered list of channels;
  // each taken beat pops one, then GAP idle cycles follow.
  int         mlist [2][4];
  int         mlen  [2];
  int         mhead [2];
  int         mgap  [2];
  logic [3:0] mdata [2];
  logic [1:0] msel  [2];
  logic       mdrop [2];

  function automatic int gapv(input int n);
    return (n == 0) ? 0 : 3;
  endfunction

  always @(negedge clk) begin : cmp
    bit b;
    for (int n = 0; n < 2; n++) begin
      b = mhead[n] < mlen[n];
      if (started) begin
        chk($sformatf("in_ready%0d", n), 8'(rdy_w[n]),
            8'(rst_n && !b && mgap[n] == 0));
        chk($sformatf("out_valid%0d", n), 8'(vld_w[n]), 8'(b));
        chk($sformatf("out_chan%0d", n), 8'(chan_w[n]), 8'(msel[n]));
        chk($sformatf("sel%0d", n), 8'(sel_w[n]), 8'(msel[n]));
        chk($sformatf("out_bit%0d", n), 8'(bit_w[n]),
            8'(b && mdata[n][msel[n]]));
        chk($sformatf("out_last%0d", n), 8'(last_w[n]),
            8'(b && mhead[n] == mlen[n] - 1));
        chk($sformatf("drop%0d", n), 8'(drop_w[n]), 8'(mdrop[n]));
        chk($sformatf("idata%0d", n), 8'(dat_w[n]), 8'(mdata[n]));
      end
      // Advance to the state after the coming rising edge.
      if (!rst_n) begin
        mlen[n]  = 0;
        mhead[n] = 0;
        mgap[n]  = 0;
        mdata[n] = 4'd0;
        msel[n]  = 2'd0;
        mdrop[n] = 1'b0;
      end else begin
        mdrop[n] = 1'b0;
        if (b) begin
          if (out_ready) begin
            mhead[n]++;
            if (mhead[n] == mlen[n]) mgap[n] = gapv(n);
            else msel[n] = 2'(mlist[n][mhead[n]]);
          end
        end else if (mgap[n] > 0) begin
          mgap[n]--;
        end else if (in_valid) begin
          mdata[n] = in_data;
          mlen[n]  = 0;
          mhead[n] = 0;
          for (int k = 0; k < 4; k++) begin
            if (chan_mask[k]) begin
              mlist[n][mlen[n]] = k;
              mlen[n]++;
            end
          end
          if (mlen[n] == 0) mdrop[n] = 1'b1;
          else msel[n] = 2'(mlist[n][0]);
        end
      end
    end
  end

  task automatic nxt;
    @(posedge clk);
    #1;
  endtask

  task automatic beat0(input logic [1:0] c, input logic b,
                       input logic l);
    chk("lit_valid", 8'(vld_w[0]), 8'd1);
    chk("lit_chan", 8'(chan_w[0]), 8'(c));
    chk("lit_bit", 8'(bit_w[0]), 8'(b));
    chk("lit_last", 8'(last_w[0]), 8'(l));
  endtask

  initial begin
    out_ready = 1'b1;
    nxt();
    nxt();
    started = 1'b1;
    @(negedge clk);
    chk("rst_ready0", 8'(rdy_w[0]), 8'd0);
    chk("rst_ready3", 8'(rdy_w[1]), 8'd0);
    chk("rst_sel", 8'(sel_w[0]), 8'd0);

    // Full mask frame.
    nxt();
    rst_n = 1'b1; in_valid = 1'b1; in_data = 4'b1010; chan_mask = 4'b1111;
    @(negedge clk);
    chk("idle_ready", 8'(rdy_w[0]), 8'd1);
    nxt();
    in_valid = 1'b0;
    @(negedge clk); beat0(2'd0, 1'b0, 1'b0);
    nxt(); @(negedge clk); beat0(2'd1, 1'b1, 1'b0);
    nxt(); @(negedge clk); beat0(2'd2, 1'b0, 1'b0);
    nxt(); @(negedge clk); beat0(2'd3, 1'b1, 1'b1);
    nxt(); @(negedge clk);
    chk("post_ready0", 8'(rdy_w[0]), 8'd1);
    chk("post_valid0", 8'(vld_w[0]), 8'd0);
    chk("gap3_c1", 8'(rdy_w[1]), 8'd0);
    nxt(); @(negedge clk); chk("gap3_c2", 8'(rdy_w[1]), 8'd0);
    nxt(); @(negedge clk); chk("gap3_c3", 8'(rdy_w[1]), 8'd0);
    nxt(); @(negedge clk); chk("gap3_end", 8'(rdy_w[1]), 8'd1);

    // Sparse mask: channels 1 and 3 only.
    in_valid = 1'b1; in_data = 4'b0110; chan_mask = 4'b1010;
    nxt();
    in_valid = 1'b0;
    @(negedge clk); beat0(2'd1, 1'b1, 1'b0);
    nxt(); @(negedge clk); beat0(2'd3, 1'b0, 1'b1);
    nxt(); @(negedge clk);
    chk("sparse_done", 8'(vld_w[0]), 8'd0);

    // Zero mask.
    in_valid = 1'b1; in_data = 4'b0101; chan_mask = 4'b0000;
    nxt();
    in_valid = 1'b0;
    @(negedge clk);
    chk("drop_pulse", 8'(drop_w[0]), 8'd1);
    chk("drop_valid", 8'(vld_w[0]), 8'd0);
    chk("drop_ready", 8'(rdy_w[0]), 8'd1);
    chk("drop_data", 8'(dat_w[0]), 8'b0101);
    nxt(); @(negedge clk);
    chk("drop_clear", 8'(drop_w[0]), 8'd0);

    // Backpressure at channel 2.
    in_valid = 1'b1; in_data = 4'b1100; chan_mask = 4'b1111;
    nxt();
    in_valid = 1'b0;
    @(negedge clk); beat0(2'd0, 1'b0, 1'b0);
    nxt(); @(negedge clk); beat0(2'd1, 1'b0, 1'b0);
    nxt();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); beat0(2'd2, 1'b1, 1'b0);
      nxt();
    end
    out_ready = 1'b1;
    @(negedge clk); beat0(2'd2, 1'b1, 1'b0);
    nxt(); @(negedge clk); beat0(2'd3, 1'b1, 1'b1);
    nxt(); @(negedge clk);
    chk("bp_done", 8'(vld_w[0]), 8'd0);

    // Reset in the middle of a frame.
    in_valid = 1'b1; in_data = 4'b1111; chan_mask = 4'b1111;
    nxt();
    in_valid = 1'b0;
    @(negedge clk); beat0(2'd0, 1'b1, 1'b0);
    nxt();
    rst_n = 1'b0;
    @(negedge clk);
    beat0(2'd1, 1'b1, 1'b0);
    chk("rst_comb_ready", 8'(rdy_w[0]), 8'd0);
    nxt(); @(negedge clk);
    chk("abort_valid", 8'(vld_w[0]), 8'd0);
    chk("abort_last", 8'(last_w[0]), 8'd0);
    chk("abort_sel", 8'(sel_w[0]), 8'd0);
    chk("abort_data", 8'(dat_w[0]), 8'd0);
    chk("abort_ready", 8'(rdy_w[0]), 8'd0);
    nxt();
    rst_n = 1'b1; in_valid = 1'b1; in_data = 4'b0101; chan_mask = 4'b0110;
    @(negedge clk);
    chk("rel_ready", 8'(rdy_w[0]), 8'd1);
    nxt();
    in_valid = 1'b0;
    @(negedge clk); beat0(2'd1, 1'b0, 1'b0);
    nxt(); @(negedge clk); beat0(2'd2, 1'b1, 1'b1);

    // Randomised traffic, checked by the model every cycle.
    for (int i = 0; i < 4000; i++) begin
      nxt();
      rst_n     = ($urandom_range(0, 149) != 0);
      in_valid  = ($urandom_range(0, 2) != 0);
      in_data   = 4'($urandom);
      chan_mask = 4'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
    end
    nxt();
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
